// File: rtl/adder_seq_slice.sv
// Sequential adder: one 3-bit ripple slice per cycle, WIDTH/3 cycles per add.
// Optional ADDER_SEQ_OVF_EN adds a registered signed-overflow output (ovf).
module adder_seq_slice #(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADDER_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NSLICE = WIDTH / 3;
    localparam int unsigned IDXW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LastIdx = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
`ifdef ADDER_SEQ_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    always_comb begin
        logic [3:0] c;
        logic [2:0] s;

        // Operands shift right each slice, so the active slice is always bits [2:0].
        c[0] = carry_q;
        s    = '0;
        for (int i = 0; i < 3; i++) begin
            s[i]     = a_q[i] ^ b_q[i] ^ c[i];
            c[i + 1] = (a_q[i] & b_q[i]) | (c[i] & (a_q[i] ^ b_q[i]));
        end

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef ADDER_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d     = a_q >> 3;
                b_d     = b_q >> 3;
                // New slice enters at the top; after NSLICE shifts every slice sits in place.
                sum_d   = (sum_q >> 3) | (WIDTH'(s) << (WIDTH - 3));
                carry_d = c[3];
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == LastIdx) begin
                    cout_d  = c[3];
`ifdef ADDER_SEQ_OVF_EN
                    ovf_d   = c[2] ^ c[3];
`endif
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        in_ready_d  = (state_d == StIdle);
        out_valid_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef ADDER_SEQ_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef ADDER_SEQ_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef ADDER_SEQ_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_adder_seq_slice.sv
// Directed and randomised self-checking bench for adder_seq_slice (WIDTH=12).
module tb_adder_seq_slice;

    localparam int unsigned WIDTH = 12;
    localparam int unsigned NSLICE = WIDTH / 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in, b_in;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef ADDER_SEQ_OVF_EN
    logic             ovf;
`endif

    int vectors = 0;
    int miscompares = 0;

    adder_seq_slice #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_in),
        .b         (b_in),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef ADDER_SEQ_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Accept one add, check latency and result, hold for n_hold cycles, then release.
    task automatic run_add(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                           input logic cv, input logic [WIDTH-1:0] exp_sum,
                           input logic exp_cout, input logic exp_ovf, input int n_hold);
        int lat;
        in_valid = 1'b1;
        a_in     = av;
        b_in     = bv;
        cin      = cv;
        tick();
        in_valid = 1'b0;
        a_in     = ~av;
        b_in     = ~bv;
        cin      = ~cv;
        check("accept_in_ready", 32'(in_ready), 32'd0);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check("latency", 32'(lat), 32'(NSLICE));
        check("sum", 32'(sum), 32'(exp_sum));
        check("cout", 32'(cout), 32'(exp_cout));
`ifdef ADDER_SEQ_OVF_EN
        check("ovf", 32'(ovf), 32'(exp_ovf));
`else
        if (exp_ovf) begin end
`endif
        for (int h = 0; h < n_hold; h++) begin
            in_valid = 1'b1;
            a_in     = WIDTH'($urandom);
            b_in     = WIDTH'($urandom);
            tick();
            check("hold_sum", 32'(sum), 32'(exp_sum));
            check("hold_cout", 32'(cout), 32'(exp_cout));
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release_out_valid", 32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [WIDTH:0]   ref_full;
        logic [WIDTH-1:0] ra, rb;
        logic             rc, rovf;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        cin       = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);

        run_add(12'hFFF, 12'h001, 1'b0, 12'h000, 1'b1, 1'b0, 0);
        run_add(12'h5A5, 12'h3C3, 1'b1, 12'h969, 1'b0, 1'b1, 0);
        run_add(12'h7FF, 12'h001, 1'b0, 12'h800, 1'b0, 1'b1, 0);
        run_add(12'h800, 12'h800, 1'b0, 12'h000, 1'b1, 1'b1, 0);
        run_add(12'hABC, 12'h123, 1'b1, 12'hBE0, 1'b0, 1'b0, 0);
        run_add(12'hFFF, 12'hFFF, 1'b1, 12'hFFF, 1'b1, 1'b0, 0);
        run_add(12'h000, 12'h000, 1'b1, 12'h001, 1'b0, 1'b0, 0);
        run_add(12'h123, 12'h456, 1'b0, 12'h579, 1'b0, 1'b0, 5);

        // Reset during RUN with the second slice pending; rst also beats in_valid.
        in_valid = 1'b1;
        a_in     = 12'hFFF;
        b_in     = 12'h001;
        cin      = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        rst      = 1'b1;
        in_valid = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        for (int i = 0; i < NSLICE + 1; i++) begin
            tick();
            check("abort_idle_out_valid", 32'(out_valid), 32'd0);
            check("abort_idle_in_ready", 32'(in_ready), 32'd1);
        end
        run_add(12'h001, 12'h002, 1'b0, 12'h003, 1'b0, 1'b0, 0);

        for (int n = 0; n < 300; n++) begin
            ra       = WIDTH'($urandom);
            rb       = WIDTH'($urandom);
            rc       = 1'($urandom);
            ref_full = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
            rovf     = (ra[WIDTH-1] == rb[WIDTH-1]) && (ref_full[WIDTH-1] != ra[WIDTH-1]);
            run_add(ra, rb, rc, ref_full[WIDTH-1:0], ref_full[WIDTH], rovf,
                    int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
